// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem request/response, redirect and decode-side valid/ready bundle
// master = fetch_unit side, slave = memory/execute/decode environment side
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    input  imem_rdata, redirect_en, redirect_target, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    output imem_rdata, redirect_en, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of DEPTH entries of type T with flush
// ports: clk, rst, i_push/i_data, i_pop, i_flush, o_head (valid when o_count != 0), o_count
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  T            i_data,
  input  logic        i_pop,
  input  logic        i_flush,
  output T            o_head,
  output logic [AW:0] o_count
);
  T              r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_data;
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/issue logic feeding a fetch FIFO toward decode, with redirect flush
// ports: clk, rst, bus (fetch_if.master); perf_fetched/perf_flushed only when FETCH_PERF_EN is defined
module fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]  r_pc;
  logic [31:0]  r_inflight_pc;
  logic         r_inflight;
  logic [AW:0]  w_count;
  logic         w_req;
  logic         w_push;
  logic         w_pop;
  logic         w_valid;
  logic         w_any;
  logic [31:0]  w_target;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;
  assign w_target    = bus.redirect_target & ~32'd3;
  assign w_any       = w_count != '0;
  assign w_valid     = !rst && w_any;
  // credit uses registered occupancy only; a pop this cycle frees space next cycle
  assign w_req       = !rst && !bus.redirect_en &&
                       (({1'b0, w_count} + (AW+2)'(r_inflight)) < (AW+2)'(DEPTH));
  // a redirect discards the response of the request issued last cycle
  assign w_push      = r_inflight && !bus.redirect_en;
  assign w_pop       = w_valid && bus.out_ready;
  assign w_push_data = '{instr: bus.imem_rdata, pc: r_inflight_pc};
  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_en),
    .o_head  (w_head),
    .o_count (w_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (bus.redirect_en) begin
      r_pc       <= w_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_pc <= r_pc + 32'd4;
    end
  end
  always_ff @(posedge clk)
    if (w_req) r_inflight_pc <= r_pc;
  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_pc;
  assign bus.out_valid    = w_valid;
  assign bus.out_instr    = w_any ? w_head.instr : '0;
  assign bus.out_pc       = w_any ? w_head.pc : '0;
  assign bus.out_pc_plus4 = w_any ? w_head.pc + 32'd4 : '0;
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (w_pop) perf_fetched <= perf_fetched + 32'd1;
      if (bus.redirect_en)
        perf_flushed <= perf_flushed + 32'(w_count) - 32'(w_pop) + 32'(r_inflight);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit with a one-cycle-latency memory model
module tb_fetch_unit;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  fetch_if bus();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif
  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BD0;
  endfunction
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hBAD0_BAD0;
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        red;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic        chk;
    logic [31:0] epc;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic r, rdy, red, input logic [31:0] tgt,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic ev, chk, input logic [31:0] epc);
    vec_t v;
    v = '{r, rdy, red, tgt, ereq, eaddr, ev, chk, epc};
    vecs.push_back(v);
  endtask
  task automatic check(input string name, input int row, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask
  task automatic drive(input logic r, rdy, red, input logic [31:0] tgt);
    rst = r;
    bus.out_ready = rdy;
    bus.redirect_en = red;
    bus.redirect_target = tgt;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    add(1,1,0,0,        0,0,       0,0,0);
    add(1,1,0,0,        0,0,       0,1,0);
    add(0,1,0,0,        1,32'h0,   0,1,0);
    add(0,1,0,0,        1,32'h4,   0,1,0);
    add(0,1,0,0,        1,32'h8,   1,1,32'h0);
    add(0,1,0,0,        1,32'hC,   1,1,32'h4);
    add(0,1,0,0,        1,32'h10,  1,1,32'h8);
    add(0,1,0,0,        1,32'h14,  1,1,32'hC);
    add(0,1,1,32'h100,  0,0,       1,1,32'h10);
    add(0,1,0,0,        1,32'h100, 0,1,0);
    add(0,1,0,0,        1,32'h104, 0,1,0);
    add(0,1,0,0,        1,32'h108, 1,1,32'h100);
    add(0,1,0,0,        1,32'h10C, 1,1,32'h104);
    add(0,1,1,32'h103,  0,0,       1,1,32'h108);
    add(0,1,0,0,        1,32'h100, 0,1,0);
    add(0,1,0,0,        1,32'h104, 0,1,0);
    add(0,1,0,0,        1,32'h108, 1,1,32'h100);
    add(0,1,1,32'h200,  0,0,       1,1,32'h104);
    add(0,1,1,32'h300,  0,0,       0,1,0);
    add(0,1,0,0,        1,32'h300, 0,1,0);
    add(0,1,0,0,        1,32'h304, 0,1,0);
    add(0,1,0,0,        1,32'h308, 1,1,32'h300);
    add(0,1,0,0,        1,32'h30C, 1,1,32'h304);
    add(1,0,0,0,        0,0,       0,0,0);
    add(0,0,0,0,        1,32'h0,   0,1,0);
    add(0,0,0,0,        1,32'h4,   0,1,0);
    add(0,0,0,0,        1,32'h8,   1,1,32'h0);
    add(0,0,0,0,        1,32'hC,   1,1,32'h0);
    for (int i = 0; i < 6; i++) add(0,0,0,0, 0,0, 1,1,32'h0);
    add(0,1,0,0,        0,0,       1,1,32'h0);
    add(0,1,0,0,        1,32'h10,  1,1,32'h4);
    add(0,1,0,0,        1,32'h14,  1,1,32'h8);
    add(0,1,0,0,        1,32'h18,  1,1,32'hC);
    add(0,1,0,0,        1,32'h1C,  1,1,32'h10);
    add(0,1,0,0,        1,32'h20,  1,1,32'h14);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].red, vecs[i].tgt);
      @(negedge clk);
      check("imem_req", i, 32'(bus.imem_req), 32'(vecs[i].ereq));
      if (vecs[i].ereq) check("imem_addr", i, bus.imem_addr, vecs[i].eaddr);
      check("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].ev));
      if (vecs[i].chk) begin
        check("out_pc", i, bus.out_pc, vecs[i].ev ? vecs[i].epc : 32'h0);
        check("out_instr", i, bus.out_instr, vecs[i].ev ? mem_word(vecs[i].epc) : 32'h0);
        check("out_pc_plus4", i, bus.out_pc_plus4, vecs[i].ev ? vecs[i].epc + 32'd4 : 32'h0);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) next_cycle();
    @(negedge clk);
    check("full_valid", 100, 32'(bus.out_valid), 32'h1);
    check("full_req", 100, 32'(bus.imem_req), 32'h0);
    check("full_head_pc", 100, bus.out_pc, 32'h18);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("rst_valid", 101, 32'(bus.out_valid), 32'h0);
    check("rst_req", 101, 32'(bus.imem_req), 32'h0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("restart_req", 102, 32'(bus.imem_req), 32'h1);
    check("restart_addr", 102, bus.imem_addr, 32'h0);
    check("restart_valid", 102, 32'(bus.out_valid), 32'h0);
    check("restart_pc", 102, bus.out_pc, 32'h0);
`ifdef FETCH_PERF_EN
    check("perf_fetched_rst", 102, perf_fetched, 32'h0);
    check("perf_flushed_rst", 102, perf_flushed, 32'h0);
`endif
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("restart_valid2", 103, 32'(bus.out_valid), 32'h1);
    check("restart_pc2", 103, bus.out_pc, 32'h0);
    check("restart_instr2", 103, bus.out_instr, mem_word(32'h0));
`ifdef FETCH_PERF_EN
    for (int i = 0; i < 4; i++) next_cycle();
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("perf_fetched", 104, perf_fetched, 32'd5);
    check("perf_flushed", 104, perf_flushed, 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
